// File: rtl/tick_rate_pkg.sv
// Shared types and helpers for the run-time prescaler controller and its callers.
package tick_rate_pkg;

  localparam int unsigned CLK_HZ    = 50_000_000;
  localparam int unsigned CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SWITCH = 2'd2
  } state_t;

  // Half-period length in clk cycles for a requested output frequency.
  function automatic logic [31:0] hz_to_div(input int unsigned hz);
    return 32'(CLK_HZ / (2 * hz));
  endfunction

endpackage

// File: rtl/tick_rate_ctrl_if.sv
// Divisor configuration port: valid/ready transfer of a new half-period plus a reject pulse.
interface tick_rate_ctrl_if #(
  parameter int unsigned CNT_W = tick_rate_pkg::CNT_W_DEF
);

  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (output cfg_valid, output cfg_div, input cfg_ready, input cfg_err);
  modport slave  (input cfg_valid, input cfg_div, output cfg_ready, output cfg_err);

endinterface

// File: rtl/tick_rate_ctrl.sv
// Run-time prescaler: start/stop control, glitch-free divisor retargeting, tick pulse and divided clock.
module tick_rate_ctrl #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned DEFAULT_HZ = 1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  tick_rate_ctrl_if.slave  cfg,
  output logic             tick,
  output logic             clk_div,
  output logic             running,
  output logic [CNT_W-1:0] cur_div
);

  import tick_rate_pkg::*;

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(CLK_HZ / (2 * DEFAULT_HZ));

  state_t           state_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] cur_div_reg;
  logic [CNT_W-1:0] pend_div_reg;
  logic             tick_reg;
  logic             clk_div_reg;
  logic             cfg_err_reg;
  logic             cfg_ready_reg;
  logic             running_reg;

  logic cfg_accept;
  logic cfg_take;
  logic terminal;

  assign cfg_accept = cfg.cfg_valid && cfg_ready_reg;
  assign cfg_take   = cfg_accept && (cfg.cfg_div != '0);
  assign terminal   = (count_reg == cur_div_reg - CNT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      cur_div_reg   <= DEF_DIV;
      pend_div_reg  <= '0;
      tick_reg      <= 1'b0;
      clk_div_reg   <= 1'b0;
      cfg_err_reg   <= 1'b0;
      cfg_ready_reg <= 1'b1;
      running_reg   <= 1'b0;
    end else begin
      cfg_err_reg <= cfg_accept && (cfg.cfg_div == '0);
      unique case (state_reg)
        IDLE: begin
          count_reg   <= '0;
          tick_reg    <= 1'b0;
          clk_div_reg <= 1'b0;
          if (cfg_take) cur_div_reg <= cfg.cfg_div;
          if (start && !stop) begin
            state_reg   <= RUN;
            running_reg <= 1'b1;
          end
        end
        RUN, SWITCH: begin
          if (stop) begin
            // A pending divisor is committed rather than dropped when stopping.
            if (state_reg == SWITCH) cur_div_reg <= pend_div_reg;
            else if (cfg_take)       cur_div_reg <= cfg.cfg_div;
            state_reg     <= IDLE;
            count_reg     <= '0;
            tick_reg      <= 1'b0;
            clk_div_reg   <= 1'b0;
            cfg_ready_reg <= 1'b1;
            running_reg   <= 1'b0;
          end else begin
            if (terminal) begin
              count_reg   <= '0;
              tick_reg    <= 1'b1;
              clk_div_reg <= ~clk_div_reg;
            end else begin
              count_reg <= count_reg + CNT_W'(1);
              tick_reg  <= 1'b0;
            end
            if (state_reg == RUN && cfg_take) begin
              pend_div_reg  <= cfg.cfg_div;
              state_reg     <= SWITCH;
              cfg_ready_reg <= 1'b0;
            end
            // New divisor only lands on a half-period boundary, so no runt phase.
            if (state_reg == SWITCH && terminal) begin
              cur_div_reg   <= pend_div_reg;
              state_reg     <= RUN;
              cfg_ready_reg <= 1'b1;
            end
          end
        end
        default: begin
          state_reg     <= IDLE;
          cfg_ready_reg <= 1'b1;
          running_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign tick          = tick_reg;
  assign clk_div       = clk_div_reg;
  assign running       = running_reg;
  assign cur_div       = cur_div_reg;
  assign cfg.cfg_ready = cfg_ready_reg;
  assign cfg.cfg_err   = cfg_err_reg;

endmodule

// File: tb/tb_tick_rate_ctrl.sv
// Directed bench for tick_rate_ctrl with DEF_DIV forced to 4 (DEFAULT_HZ = 6.25 MHz).
module tb_tick_rate_ctrl;

  localparam int unsigned CNT_W = 32;

  logic             clk;
  logic             rst;
  logic             start;
  logic             stop;
  logic             tick;
  logic             clk_div;
  logic             running;
  logic [CNT_W-1:0] cur_div;

  int n_cmp;
  int n_bad;
  int n;

  tick_rate_ctrl_if #(.CNT_W(CNT_W)) cfg_bus ();

  tick_rate_ctrl #(
    .CLK_HZ    (50_000_000),
    .DEFAULT_HZ(6_250_000),
    .CNT_W     (CNT_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .stop   (stop),
    .cfg    (cfg_bus.slave),
    .tick   (tick),
    .clk_div(clk_div),
    .running(running),
    .cur_div(cur_div)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %-14s observed %0d expected %0d", tag, obs, exp);
  endtask

  // Cycles until the next tick, capped so a dead DUT still terminates.
  task automatic wait_tick(output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (tick !== 1'b1 && cycles < 40);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_div = '0;

    // Reset values
    #3 rst = 1'b0;
    #20;
    check("rst_tick", 32'(tick), 0);
    check("rst_clkdiv", 32'(clk_div), 0);
    check("rst_running", 32'(running), 0);
    check("rst_curdiv", cur_div, 4);
    check("rst_ready", 32'(cfg_bus.cfg_ready), 1);
    check("rst_err", 32'(cfg_bus.cfg_err), 0);
    rst = 1'b1;
    step();

    // Default divisor: first tick 4 cycles after start, clk_div period 8
    start = 1'b1; step(); start = 1'b0;
    check("def_running", 32'(running), 1);
    wait_tick(n); check("def_first", 32'(n), 4);
    check("def_rise", 32'(clk_div), 1);
    wait_tick(n); check("def_second", 32'(n), 4);
    check("def_fall", 32'(clk_div), 0);
    stop = 1'b1; step(); stop = 1'b0;
    check("stop_running", 32'(running), 0);
    check("stop_clkdiv", 32'(clk_div), 0);

    // IDLE config applies at once; zero divisor is rejected
    cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_div = tick_rate_pkg::hz_to_div(8_333_333);
    step(); cfg_bus.cfg_valid = 1'b0;
    check("idle_curdiv", cur_div, 3);
    check("idle_noerr", 32'(cfg_bus.cfg_err), 0);
    cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_div = '0;
    step(); cfg_bus.cfg_valid = 1'b0;
    check("zero_err", 32'(cfg_bus.cfg_err), 1);
    check("zero_curdiv", cur_div, 3);
    step();
    check("zero_errpulse", 32'(cfg_bus.cfg_err), 0);
    start = 1'b1; step(); start = 1'b0;
    wait_tick(n); check("div3_first", 32'(n), 3);
    wait_tick(n); check("div3_second", 32'(n), 3);

    // RUN retarget 5 -> 2 offered at count=1
    stop = 1'b1; step(); stop = 1'b0;
    cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_div = 5; start = 1'b1;
    step(); cfg_bus.cfg_valid = 1'b0; start = 1'b0;
    check("div5_curdiv", cur_div, 5);
    step();
    check("run_ready", 32'(cfg_bus.cfg_ready), 1);
    cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_div = 2;
    step(); cfg_bus.cfg_valid = 1'b0;
    check("sw_ready", 32'(cfg_bus.cfg_ready), 0);
    check("sw_curdiv", cur_div, 5);
    check("sw_running", 32'(running), 1);
    wait_tick(n); check("sw_tail", 32'(n), 3);
    check("sw_commit", cur_div, 2);
    check("sw_ready_back", 32'(cfg_bus.cfg_ready), 1);
    wait_tick(n); check("div2_first", 32'(n), 2);
    wait_tick(n); check("div2_second", 32'(n), 2);

    // Stop while 7 is pending: committed, then used after restart
    cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_div = 7;
    step(); cfg_bus.cfg_valid = 1'b0;
    check("pend_ready", 32'(cfg_bus.cfg_ready), 0);
    stop = 1'b1; step(); stop = 1'b0;
    check("pstop_running", 32'(running), 0);
    check("pstop_clkdiv", 32'(clk_div), 0);
    check("pstop_tick", 32'(tick), 0);
    check("pstop_curdiv", cur_div, 7);
    start = 1'b1; step(); start = 1'b0;
    wait_tick(n); check("div7_first", 32'(n), 7);

    // start&stop together in IDLE, then div=1
    stop = 1'b1; step();
    start = 1'b1; step(); start = 1'b0; stop = 1'b0;
    check("ss_running", 32'(running), 0);
    cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_div = 1;
    step(); cfg_bus.cfg_valid = 1'b0;
    check("div1_curdiv", cur_div, 1);
    start = 1'b1; step(); start = 1'b0;
    check("div1_e0_tick", 32'(tick), 0);
    step();
    check("div1_tick_a", 32'(tick), 1);
    check("div1_clk_a", 32'(clk_div), 1);
    step();
    check("div1_tick_b", 32'(tick), 1);
    check("div1_clk_b", 32'(clk_div), 0);
    step();
    check("div1_clk_c", 32'(clk_div), 1);

    // Async reset mid-half-period in SWITCH
    stop = 1'b1; step(); stop = 1'b0;
    cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_div = 6; start = 1'b1;
    step(); cfg_bus.cfg_valid = 1'b0; start = 1'b0;
    wait_tick(n); check("div6_first", 32'(n), 6);
    step();
    cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_div = 3;
    step(); cfg_bus.cfg_valid = 1'b0;
    check("ar_ready", 32'(cfg_bus.cfg_ready), 0);
    check("ar_clkdiv_pre", 32'(clk_div), 1);
    #2 rst = 1'b0;
    #1;
    check("ar_clkdiv", 32'(clk_div), 0);
    check("ar_running", 32'(running), 0);
    check("ar_tick", 32'(tick), 0);
    check("ar_curdiv", cur_div, 4);
    check("ar_ready_idle", 32'(cfg_bus.cfg_ready), 1);
    #2 rst = 1'b1;
    step();
    start = 1'b1; step(); start = 1'b0;
    wait_tick(n); check("ar_restart", 32'(n), 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
